// File: rtl/mult_pkg.sv
// Shared types and constants for the 3x3-bit repeated-addition multiplier
// (controller, datapath and top level all import this package).
package mult_pkg;

  localparam int unsigned OP_WIDTH = 3;
  localparam int unsigned ALU_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    ADD,
    COUNT,
    STORE,
    DONE
  } state_t;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_INC = 2'b01;
  localparam logic [ALU_W-1:0] ALU_CLR = 2'b10;

  localparam logic MUX1_R1 = 1'b0;
  localparam logic MUX1_A  = 1'b1;
  localparam logic MUX2_A  = 1'b0;
  localparam logic MUX2_R2 = 1'b1;

  // Strobe bundle driven towards the datapath and the system handshake.
  typedef struct packed {
    logic             mux_in1;
    logic             mux_in2;
    logic [ALU_W-1:0] alu_cont;
    logic             load_a;
    logic             load_b;
    logic             load_r1;
    logic             load_r2;
    logic             load_f;
    logic             busy;
    logic             done;
  } ctrl_t;

  // Moore output decode; anything not listed for a state stays at zero.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      LOAD: begin
        c.load_a = 1'b1;
        c.load_b = 1'b1;
      end
      CLEAR: begin
        c.alu_cont = ALU_CLR;
        c.load_r1  = 1'b1;
        c.load_r2  = 1'b1;
      end
      ADD: begin
        c.mux_in1  = MUX1_R1;
        c.mux_in2  = MUX2_A;
        c.alu_cont = ALU_ADD;
        c.load_r1  = 1'b1;
      end
      COUNT: begin
        c.mux_in2  = MUX2_R2;
        c.alu_cont = ALU_INC;
        c.load_r2  = 1'b1;
      end
      STORE:   c.load_f = 1'b1;
      DONE:    c.done   = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Controller-side bundle: system handshake, datapath compare input and
// datapath select/ALU/load strobes.
interface mult_ctrl_if;

  logic                               START;
  logic [mult_pkg::OP_WIDTH-1:0]      B;
  logic                               R2_LT_B_1;
  logic                               MUX_IN1_CONT;
  logic                               MUX_IN2_CONT;
  logic [mult_pkg::ALU_W-1:0]         ALU_CONT;
  logic                               LOAD_A_REG;
  logic                               LOAD_B_REG;
  logic                               LOAD_R1_REG;
  logic                               LOAD_R2_REG;
  logic                               LOAD_F_REG;
  logic                               BUSY;
  logic                               DONE;
  logic                               ERR;

  modport master (
    output START, B, R2_LT_B_1,
    input  MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT,
    input  LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_F_REG,
    input  BUSY, DONE, ERR
  );

  modport slave (
    input  START, B, R2_LT_B_1,
    output MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT,
    output LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_F_REG,
    output BUSY, DONE, ERR
  );

endinterface

// File: rtl/mult_controller.sv
// Control FSM for the repeated-addition multiplier datapath: sequences
// load/clear/add/count/store and provides the START/BUSY/DONE/ERR handshake.
module mult_controller
  import mult_pkg::*;
#(
  parameter int unsigned OP_W     = OP_WIDTH,
  parameter int unsigned MAX_ITER = (1 << OP_W) - 1
) (
  input  logic        SYS_CLOCK,
  input  logic        SYS_RESET_N,
  mult_ctrl_if.slave  bus
);

  state_t          state_q;
  state_t          state_nxt;
  ctrl_t           ctrl_q;
  logic [OP_W-1:0] iter_cnt;
  logic            b_zero_q;
  logic            err_q;
  logic            err_set;

  // Next-state logic; the COUNT decision uses the pre-increment R2 compare.
  always_comb begin
    state_nxt = state_q;
    err_set   = 1'b0;
    case (state_q)
      IDLE:  if (bus.START) state_nxt = LOAD;
      LOAD:  state_nxt = CLEAR;
      CLEAR: state_nxt = b_zero_q ? STORE : ADD;
      ADD:   state_nxt = COUNT;
      COUNT: begin
        if (bus.R2_LT_B_1) begin
          if (iter_cnt < OP_W'(MAX_ITER)) begin
            state_nxt = ADD;
          end else begin
            state_nxt = STORE;
            err_set   = 1'b1;
          end
        end else begin
          state_nxt = STORE;
        end
      end
      STORE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      iter_cnt <= '0;
      b_zero_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_state(state_nxt);
      if (state_q == LOAD) begin
        b_zero_q <= (bus.B == '0);
        err_q    <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (state_q == CLEAR) begin
        iter_cnt <= '0;
      end else if (state_q == ADD) begin
        iter_cnt <= iter_cnt + OP_W'(1);
      end
    end
  end

  assign bus.MUX_IN1_CONT = ctrl_q.mux_in1;
  assign bus.MUX_IN2_CONT = ctrl_q.mux_in2;
  assign bus.ALU_CONT     = ctrl_q.alu_cont;
  assign bus.LOAD_A_REG   = ctrl_q.load_a;
  assign bus.LOAD_B_REG   = ctrl_q.load_b;
  assign bus.LOAD_R1_REG  = ctrl_q.load_r1;
  assign bus.LOAD_R2_REG  = ctrl_q.load_r2;
  assign bus.LOAD_F_REG   = ctrl_q.load_f;
  assign bus.BUSY         = ctrl_q.busy;
  assign bus.DONE         = ctrl_q.done;
  assign bus.ERR          = err_q;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: drives it against a behavioural multiplier
// datapath and scores each DONE against hand-computed product/latency/ERR.
module tb_mult_controller;

  logic SYS_CLOCK = 1'b0;
  logic SYS_RESET_N;
  mult_ctrl_if bus ();

  mult_controller dut (
    .SYS_CLOCK   (SYS_CLOCK),
    .SYS_RESET_N (SYS_RESET_N),
    .bus         (bus)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  int cyc = 0;
  always @(posedge SYS_CLOCK) cyc <= cyc + 1;

  // Behavioural datapath (F_REG deliberately has no reset).
  logic [2:0] a_in, a_reg, b_reg, r2_q, b_m1;
  logic [5:0] r1_q, f_q, alu_in1, alu_in2, alu_out;
  logic       force_lt;

  assign b_m1    = b_reg - 3'd1;
  assign alu_in1 = bus.MUX_IN1_CONT ? {3'b000, a_reg} : r1_q;
  assign alu_in2 = bus.MUX_IN2_CONT ? {3'b000, r2_q} : {3'b000, a_reg};
  assign alu_out = (bus.ALU_CONT == 2'b00) ? alu_in1 + alu_in2 :
                   (bus.ALU_CONT == 2'b01) ? alu_in2 + 6'd1 : 6'd0;
  assign bus.R2_LT_B_1 = force_lt | (r2_q < b_m1);

  always @(posedge SYS_CLOCK) begin
    if (bus.LOAD_A_REG)  a_reg <= a_in;
    if (bus.LOAD_B_REG)  b_reg <= bus.B;
    if (bus.LOAD_R1_REG) r1_q  <= alu_out;
    if (bus.LOAD_R2_REG) r2_q  <= alu_out[2:0];
    if (bus.LOAD_F_REG)  f_q   <= r1_q;
  end

  typedef struct {
    int f;
    int cyc;
    int err;
    int r1n;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   r1_cnt   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.MUX_IN1_CONT, bus.MUX_IN2_CONT, bus.ALU_CONT, bus.LOAD_A_REG,
            bus.LOAD_B_REG, bus.LOAD_R1_REG, bus.LOAD_R2_REG, bus.LOAD_F_REG,
            bus.BUSY, bus.DONE, bus.ERR};
  endfunction

  // Monitor: pops one expectation per DONE pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge SYS_CLOCK);
      if (SYS_RESET_N) begin
        if (bus.LOAD_A_REG)  r1_cnt = 0;
        if (bus.LOAD_R1_REG) r1_cnt++;
        if (bus.DONE) begin
          done_cnt++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=DONE required=no DONE (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("product", int'(f_q), e.f);
            chk("done_cycle", cyc, e.cyc);
            chk("err", int'(bus.ERR), e.err);
            chk("r1_loads", r1_cnt, e.r1n);
          end
        end
      end
    end
  end

  // Start one operation; cycle 0 is the IDLE cycle in which START is sampled.
  task automatic issue(input logic [2:0] a, input logic [2:0] b, input int f,
                       input int lat, input int err, input int r1n, input bit push);
    exp_t e;
    @(negedge SYS_CLOCK);
    a_in      = a;
    bus.B     = b;
    bus.START = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    e.f = f; e.cyc = cyc + lat - 1; e.err = err; e.r1n = r1n;
    if (push) sb.push_back(e);
    @(negedge SYS_CLOCK);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge SYS_CLOCK);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    int         f;
    int         lat;
    int         r1n;
  } vec_t;

  vec_t vecs[5] = '{
    '{3'd3, 3'd4, 12, 12, 5},
    '{3'd5, 3'd0,  0,  4, 1},
    '{3'd0, 3'd6,  0, 16, 7},
    '{3'd7, 3'd7, 49, 18, 8},
    '{3'd6, 3'd1,  6,  6, 2}
  };

  initial begin
    int   base;
    exp_t e;
    SYS_RESET_N = 1'b0;
    bus.START   = 1'b0;
    bus.B       = '0;
    a_in        = '0;
    force_lt    = 1'b0;
    #2;
    chk("reset_outputs", int'(outs()), 0);
    repeat (3) @(negedge SYS_CLOCK);
    SYS_RESET_N = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].lat, 0, vecs[i].r1n, 1'b1);
      wait_done(done_cnt + 1, 60);
    end

    // START re-pulsed while busy must not start a second operation.
    base = done_cnt;
    issue(3'd4, 3'd2, 8, 8, 0, 3, 1'b1);
    @(negedge SYS_CLOCK);
    bus.START = 1'b1;
    @(negedge SYS_CLOCK);
    bus.START = 1'b0;
    wait_done(base + 1, 60);
    repeat (10) @(negedge SYS_CLOCK);
    chk("single_done", done_cnt, base + 1);
    chk("idle_after_done", int'(bus.BUSY), 0);

    // Reset during ADD aborts without storing.
    issue(3'd2, 3'd5, 0, 0, 0, 0, 1'b0);
    @(posedge SYS_CLOCK);
    @(posedge SYS_CLOCK);
    @(negedge SYS_CLOCK);
    chk("in_add_load_r1", int'(bus.LOAD_R1_REG), 1);
    SYS_RESET_N = 1'b0;
    #1;
    chk("abort_outputs", int'(outs()), 0);
    chk("abort_busy", int'(bus.BUSY), 0);
    repeat (3) @(negedge SYS_CLOCK);
    chk("abort_f_kept", int'(f_q), 8);
    SYS_RESET_N = 1'b1;
    issue(3'd2, 3'd5, 10, 14, 0, 6, 1'b1);
    wait_done(done_cnt + 1, 60);

    // START held high: back-to-back operations.
    base = done_cnt;
    @(negedge SYS_CLOCK);
    a_in      = 3'd2;
    bus.B     = 3'd3;
    bus.START = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    e.f = 6; e.cyc = cyc + 9; e.err = 0; e.r1n = 4;
    sb.push_back(e);
    e.cyc = cyc + 20;
    sb.push_back(e);
    wait_done(base + 1, 60);
    #1;
    chk("b2b_idle_gap", int'(bus.BUSY), 0);
    @(posedge SYS_CLOCK);
    #1;
    chk("b2b_reload", int'(bus.LOAD_A_REG), 1);
    bus.START = 1'b0;
    wait_done(base + 2, 60);

    // Watchdog: compare stuck at 1 gives 7 additions and ERR.
    force_lt = 1'b1;
    issue(3'd1, 3'd2, 7, 18, 1, 8, 1'b1);
    wait_done(done_cnt + 1, 60);
    force_lt = 1'b0;
    issue(3'd3, 3'd3, 9, 10, 0, 4, 1'b1);
    @(posedge SYS_CLOCK);
    #1;
    chk("err_cleared_after_load", int'(bus.ERR), 0);
    wait_done(done_cnt + 1, 60);

    repeat (4) @(negedge SYS_CLOCK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
